parity_arbiter: RTL
===================

# parity_arbiter

Round-robin scheduler that shares one 8-bit parity unit (XOR-reduce of a byte) among up to `N_REQ` requesters. Each requester presents a byte and holds a request. The arbiter grants one requester at a time, latches its byte, and computes the odd/even parity. It then returns the result with a done pulse. It sits between the switch/byte sources and the LED/status logic, replacing per-source parity trees with one sequenced shared unit.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width per requester.
- `IDW`, default 3: width of `res_id`; must be ≥ clog2(`N_REQ`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `N_REQ`: request from each requester; held until its `done` pulse.
- `data` in `N_REQ*DW`: byte for requester i at `[i*DW +: DW]`; must be stable while `req[i]` is high.
- `gnt` out `N_REQ`: one-hot grant, high for the whole service window.
- `done` out `N_REQ`: one-cycle pulse to the served requester.
- `busy` out 1: high whenever state ≠ IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res_id` out `IDW`: index of the requester served.
- `res_par` out 1: XOR of the latched byte; 1 = odd number of ones.
- `res_even` out 1: complement of `res_par`, updated at the same time.
- `odd_cnt` out 16: statistics, see Configuration.
- `total_cnt` out 16: statistics, see Configuration.

## Operation
- FSM states:
  - IDLE → LOAD when any `req` bit is high; winner chosen and `gnt` set at this edge.
  - LOAD → CALC: `data_r` ← data slice of the winner.
  - CALC → DONE: `par_r` ← ^`data_r`.
  - DONE → IDLE: unconditional.
- Arbitration:
  - Round-robin search starting at `last_id+1` mod `N_REQ`.
  - `last_id` ← winner on entering LOAD.
  - `last_id` resets to `N_REQ-1`, so the lowest pending index wins first after reset.
- Requests are sampled only in IDLE. `req` changes during LOAD/CALC/DONE do not alter the current service.
- If `req[id]` drops before DONE, service still completes and the result is reported.
- During DONE:
  - `res_valid` = 1 and `done[id]` = 1.
  - `res_id`, `res_par` and `res_even` update on entry to DONE and hold their values until the next DONE.
- All outputs are registered.
- Reset values: all outputs 0 (including `res_even`), state IDLE, `last_id` = `N_REQ-1`, counters 0.
- Reset mid-operation (any state) aborts the service:
  - Next cycle `gnt`, `done`, `res_valid` and `busy` are 0.
  - No done pulse is issued for the aborted requester.
- Requester indices ≥ `N_REQ` do not exist; `res_id` upper bits are 0.

## Timing
- Let cycle t be the IDLE cycle in which `req` is sampled high.
- Per-cycle outputs:
  - t+1 (LOAD): `gnt` one-hot, `busy` = 1.
  - t+2 (CALC): `gnt` and `busy` still high.
  - t+3 (DONE): `gnt`, `res_valid` and `done[id]` high.
  - t+4 (IDLE): `gnt` = 0, `busy` = 0.
- Request-to-result latency is 3 cycles. Each service occupies 4 cycles (LOAD, CALC, DONE, IDLE).
- Throughput: one result every 4 cycles under continuous requests.
- The requester drops `req` on the edge ending t+3, so it is low in t+4 and is not re-granted.
- A requester that keeps `req` high in t+4 is treated as a new request. It competes under round-robin, so it is deferred if others are pending.
- Simultaneous requests: exactly one grant, by round-robin order; never more than one `gnt` bit high.

## Configuration
- `PARITY_ARB_STATS_EN` defined:
  - `total_cnt` increments on every DONE.
  - `odd_cnt` increments on every DONE with `res_par` = 1.
  - Both saturate at 16'hFFFF and clear on `reset`.
- Not defined: counter logic is omitted, and `odd_cnt` and `total_cnt` are tied to 0.

## Test plan
- Reset, then `req[0]`=1 with byte 8'h07 → `gnt` = 4'b0001 for t+1..t+3; at t+3 `res_valid` = 1, `done[0]` = 1, `res_id` = 0, `res_par` = 1, `res_even` = 0.
- `req[2]` with 8'hFF → at t+3 `res_id` = 2, `res_par` = 0, `res_even` = 1; 8'h00 → `res_par` = 0; 8'h80 → `res_par` = 1.
- All four requesters request with 8'h01/03/07/0F, each dropping after its `done` → service order 0, 1, 2, 3; `res_par` = 1, 0, 1, 0; `res_valid` pulses 4 cycles apart.
- `req[0]` and `req[3]` held continuously → grants alternate 0, 3, 0, 3; never two `gnt` bits high at once.
- `reset` pulsed during CALC while serving requester 1, with requesters 1 and 2 pending → next cycle all outputs 0 and no `done[1]`; after release requester 1 is served first (`last_id` = 3).
- With `PARITY_ARB_STATS_EN`, 3 odd bytes and 2 even bytes → `odd_cnt` = 3, `total_cnt` = 5. Without the macro, both stay 0.

Source files
------------

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one byte-parity unit among N_REQ requesters.
// Optional statistics counters are enabled with `define PARITY_ARB_STATS_EN.
module parity_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned IDW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*DW-1:0]  data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic                 res_par,
  output logic                 res_even,
  output logic [15:0]          odd_cnt,
  output logic [15:0]          total_cnt
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] id_r;
  logic [DW-1:0]  data_r;
  logic [IDW-1:0] hi_id, lo_id, win_id;
  logic           hi_found, lo_found, win_found;

  // Round-robin pick: first pending index above last_id, else first pending overall.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i] && !hi_found && (IDW'(i) > last_id)) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_found) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CALC;
      S_CALC:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced alongside the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id   <= IDW'(N_REQ - 1);
      id_r      <= '0;
      data_r    <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_par   <= 1'b0;
      res_even  <= 1'b0;
    end else begin
      busy      <= (state_nx != S_IDLE);
      res_valid <= 1'b0;
      done      <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt     <= N_REQ'(1) << win_id;
            id_r    <= win_id;
            last_id <= win_id;
          end
        end
        S_LOAD: data_r <= data[32'(id_r)*DW +: DW];
        S_CALC: begin
          res_valid <= 1'b1;
          done      <= gnt;
          res_id    <= id_r;
          res_par   <= ^data_r;
          res_even  <= ~(^data_r);
        end
        S_DONE: gnt <= '0;
        default: gnt <= '0;
      endcase
    end
  end

`ifdef PARITY_ARB_STATS_EN
  // Saturating counters, bumped on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      odd_cnt   <= '0;
      total_cnt <= '0;
    end else if (state == S_CALC) begin
      if (total_cnt != {CW{1'b1}}) total_cnt <= total_cnt + CW'(1);
      if ((^data_r) && (odd_cnt != {CW{1'b1}})) odd_cnt <= odd_cnt + CW'(1);
    end
  end
`else
  assign odd_cnt   = '0;
  assign total_cnt = '0;
`endif

endmodule
